// File: rtl/zoh_sched_pkg.sv
// Shared types and helpers for the ZOH sample-rate scheduler.
// Holds the scheduler state encoding and a saturating-increment helper.
package zoh_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } sched_state_t;

    // Increment v, sticking at the all-ones value of a w-bit counter.
    // Counters of up to 32 bits are supported.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_skid1.sv
// Single-entry AXI-Stream input buffer with a synchronous flush.
// Ports: en gates s_tready; consume empties the entry; flush discards it.
module axis_skid1 #(
    parameter int WIDTH = 24
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             consume,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic             buf_valid,
    output logic [WIDTH-1:0] buf_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             accept;

    // Ready only while empty, so an entry is never refilled in the
    // cycle it is consumed.
    assign s_tready  = en & ~valid_q;
    assign accept    = s_tvalid & s_tready;
    assign buf_valid = valid_q;
    assign buf_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = s_tdata;
        end
        if (consume) begin
            valid_d = 1'b0;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axis_zoh_sched.sv
// Sample-rate scheduler feeding the ZOH/CIC interpolator: one beat per R
// cycles from an upstream AXIS source, with underrun substitution.
// Ports: aclk/arst_n (sync, active-low); enable, underrun_zero,
// clear_counts controls; s_axis_* upstream; m_axis_* to ZOH; running,
// underrun pulse, underrun_count and stall_count status (CNT_W <= 32).
module axis_zoh_sched
    import zoh_sched_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int R     = 100,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic             underrun_zero,
    input  logic             clear_counts,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             running,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CW = (R > 2) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] last_d;
    logic [WIDTH-1:0] m_data_q;
    logic [WIDTH-1:0] m_data_d;
    logic             m_valid_q;
    logic             m_valid_d;
    logic             under_q;
    logic             under_d;
    logic             running_q;
    logic             running_d;
    logic [CNT_W-1:0] ucnt_q;
    logic [CNT_W-1:0] ucnt_d;
    logic [CNT_W-1:0] scnt_q;
    logic [CNT_W-1:0] scnt_d;

    logic             buf_en;
    logic             flush;
    logic             consume;
    logic             buf_valid;
    logic [WIDTH-1:0] buf_data;
    logic             tick;
    logic             m_free;

    assign buf_en = (state_q == PRIME) || (state_q == RUN);

    axis_skid1 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .en        (buf_en),
        .flush     (flush),
        .consume   (consume),
        .s_tdata   (s_axis_tdata),
        .s_tvalid  (s_axis_tvalid),
        .s_tready  (s_axis_tready),
        .buf_valid (buf_valid),
        .buf_data  (buf_data)
    );

    assign tick   = (state_q == RUN) && (cnt_q == '0);
    // Output slot is free if empty or being taken this cycle.
    assign m_free = ~m_valid_q | m_axis_tready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        flush     = 1'b0;
        consume   = 1'b0;
        m_valid_d = m_valid_q & ~m_axis_tready;
        m_data_d  = m_data_q;
        last_d    = last_q;
        under_d   = 1'b0;
        ucnt_d    = ucnt_q;
        scnt_d    = scnt_q;

        if (tick) begin
            if (m_free) begin
                m_valid_d = 1'b1;
                if (buf_valid) begin
                    m_data_d = buf_data;
                    last_d   = buf_data;
                    consume  = 1'b1;
                end else begin
                    m_data_d = underrun_zero ? '0 : last_q;
                    under_d  = 1'b1;
                    ucnt_d   = CNT_W'(sat_inc(32'(ucnt_q), CNT_W));
                end
            end else begin
                // Beat still pending: this slot is lost to back-pressure.
                scnt_d = CNT_W'(sat_inc(32'(scnt_q), CNT_W));
            end
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (buf_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (m_free) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                flush   = 1'b1;
            end
        endcase

        if (clear_counts) begin
            ucnt_d = '0;
            scnt_d = '0;
        end

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            under_q   <= 1'b0;
            running_q <= 1'b0;
            ucnt_q    <= '0;
            scnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            under_q   <= under_d;
            running_q <= running_d;
            ucnt_q    <= ucnt_d;
            scnt_q    <= scnt_d;
        end
    end

    assign m_axis_tdata   = m_data_q;
    assign m_axis_tvalid  = m_valid_q;
    assign running        = running_q;
    assign underrun       = under_q;
    assign underrun_count = ucnt_q;
    assign stall_count    = scnt_q;

endmodule

// File: doc/axis_zoh_sched.md
Name: axis_zoh_sched

Overview:
- Sample-rate scheduler in front of the zero-order-hold / CIC interpolator of the DSM DAC path.
- Pulls one sample from an upstream AXI-Stream source (FIFO, DMA, test generator) exactly once every R aclk cycles and issues it as a single beat to the ZOH input.
- The ZOH then sees a clean 1/R-rate strobe instead of raw upstream valid.
- Handles start/stop sequencing, underrun substitution (hold last or zero), downstream-stall detection, and status counters.

Parameters:
- WIDTH, 24, sample width (matches ZOH/CIC data width: 16 + 7 growth + 1 sign).
- R, 100, interpolation ratio; one output beat per R cycles; legal range R >= 2.
- CNT_W, 16, width of underrun_count and stall_count.

Ports:
- aclk  in  1  clock
- arst_n  in  1  reset
- enable  in  1  level; 1 = run the scheduler, 0 = stop
- underrun_zero  in  1  underrun policy: 0 = repeat last emitted sample, 1 = emit zero
- clear_counts  in  1  single-cycle pulse; zeroes both status counters
- s_axis_tdata  in  WIDTH  upstream sample
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  WIDTH  sample to ZOH
- m_axis_tvalid  out  1  beat valid to ZOH
- m_axis_tready  in  1  ZOH ready
- running  out  1  high in PRIME, RUN or STOP
- underrun  out  1  one-cycle pulse per substituted beat
- underrun_count  out  CNT_W  saturating count of substituted beats
- stall_count  out  CNT_W  saturating count of ticks lost to downstream back-pressure

Behaviour:
- Reset: already decided — reset arst_n, synchronous, active-low; clock aclk. While reset is asserted:
  - state = IDLE, tick counter = 0, buffer empty, last_sample = 0.
  - m_axis_tdata = 0, m_axis_tvalid = 0, s_axis_tready = 0.
  - running = 0, underrun = 0, both counters = 0.
- Input buffer:
  - Single-entry register (buf_valid, buf_data).
  - s_axis_tready = ~buf_valid, only in states PRIME and RUN; 0 in IDLE and STOP.
  - Accept occurs when s_axis_tvalid && s_axis_tready.
  - The buffer is not refilled in the same cycle it is consumed; R >= 2 guarantees throughput.
- Tick counter:
  - Counts 0..R-1 in RUN and wraps R-1 -> 0.
  - tick = (state == RUN) && (cnt == 0).
  - Cleared to 0 on entry to RUN.
- On tick with m_axis_tvalid == 0 (or accepted in the same cycle):
  - If buf_valid: m_axis_tdata <= buf_data; last_sample <= buf_data; buffer emptied.
  - Else: m_axis_tdata <= underrun_zero ? 0 : last_sample; pulse underrun for one cycle; underrun_count++ (saturating).
  - m_axis_tvalid <= 1 in both cases.
- On tick with m_axis_tvalid == 1 and m_axis_tready == 0:
  - Pending beat is held unchanged and the buffer is not consumed.
  - stall_count++ (saturating).
- m_axis_tvalid/tdata follow AXIS rules: once asserted, they are stable until the m_axis_tvalid && m_axis_tready handshake, then tvalid drops.
- State machine:
  - IDLE -> PRIME when enable = 1. Buffer is empty on entry to IDLE.
  - PRIME -> RUN when buf_valid = 1. Waits indefinitely otherwise; no underruns are counted in PRIME.
  - PRIME -> IDLE when enable = 0. Buffer is flushed.
  - RUN -> STOP when enable = 0. No further ticks; the pending beat, if any, completes.
  - STOP -> IDLE once m_axis_tvalid == 0 (or it is handshaking this cycle). Buffer is flushed; last_sample is kept.
  - A re-assert of enable while in STOP is ignored until IDLE is reached.
- Latency:
  - Upstream accept in cycle c -> buf_valid in c+1 -> RUN in c+2 (tick) -> m_axis_tvalid = 1 in c+3.
  - Thereafter one beat every R cycles, exactly, while m_axis_tready = 1.
- clear_counts zeroes both counters. If it coincides with an increment, clear wins.
- Counters saturate at 2^CNT_W - 1.

Decomposition:
- Package zoh_sched_pkg:
  - state enum sched_state_t {IDLE, PRIME, RUN, STOP}.
  - Helper function for the saturating increment.
- Natural sub-module: axis_skid1, the single-entry input buffer with flush input.
- Counter logic and FSM stay in the top module.

Test Plan:
- R=4, upstream always valid with values 1,2,3,..., enable at t0:
  - m beats 1,2,3,... are spaced exactly 4 cycles apart.
  - First m_axis_tvalid appears 3 cycles after the first accept.
  - underrun_count stays 0.
- R=4, upstream stops after sample 5, underrun_zero=0:
  - Subsequent beats repeat 5.
  - underrun pulses once per tick.
  - underrun_count increments by 1 per tick.
- Same stimulus with underrun_zero=1:
  - Beats after 5 are 0.
  - When upstream resumes with 9, the next tick emits 9.
- m_axis_tready held low for 10 cycles with R=4:
  - Pending beat data stays stable.
  - stall_count = 2 or 3, depending on tick phase.
  - No buffered sample is lost: it emits after tready returns.
- enable dropped mid-RUN while a beat is pending and tready is low:
  - State stays STOP until tready rises and the beat handshakes.
  - Then IDLE, s_axis_tready = 0, running = 0.
  - Re-enable primes again from an empty buffer.
- Reset asserted mid-RUN, and clear_counts pulsed together with an underrun tick:
  - All outputs return to 0 the next cycle.
  - Counter reads 0 after the clear/increment collision.
